// File: rtl/mem_stage_lsu.sv
// Memory-access stage: ALU ops and misaligned accesses retire after 1 cycle, legal loads/stores after the dmem handshake.
// busy holds upstream while an access is outstanding; a completion under stall is buffered until stall drops.
module mem_stage_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_AW-1:0] write_reg_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [31:0]       inst_in,
    input  logic              stall,
    output logic              busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] final_result,
    output logic [REG_AW-1:0] write_reg_out,
    output logic              reg_write_out,
    output logic [31:0]       inst_out,
    output logic              addr_err
);
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, next_state;

    logic [OFF_W-1:0]  in_off;
    logic              is_mem;
    logic              misaligned;
    logic              accept;
    logic [BE_W-1:0]   size_mask;
    logic [BE_W-1:0]   be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [ADDR_W-1:0] addr_next;

    logic [DATA_W-1:0] cap_alu;
    logic [REG_AW-1:0] cap_reg;
    logic              cap_rw;
    logic [31:0]       cap_inst;
    logic              cap_load;
    logic [1:0]        cap_size;
    logic              cap_uns;
    logic [OFF_W-1:0]  cap_off;
    logic [DATA_W-1:0] res_q;

    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] keep;
    logic              sign_bit;
    logic [DATA_W-1:0] load_fmt;

    logic              start_req;
    logic              retire;
    logic              park;
    logic [DATA_W-1:0] ret_result;
    logic [REG_AW-1:0] ret_reg;
    logic              ret_rw;
    logic [31:0]       ret_inst;
    logic              ret_err;

    assign busy      = (state != IDLE);
    assign in_off    = alu_result[OFF_W-1:0];
    assign is_mem    = mem_read_in | mem_write_in;
    assign accept    = (state == IDLE) && in_valid && !stall;
    assign addr_next = {alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign be_next   = size_mask << in_off;

    // Per-size alignment check, byte-enable pattern and lane-replicated store data.
    always_comb begin
        misaligned = 1'b0;
        size_mask  = '1;
        wdata_next = write_data;
        case (mem_size)
            2'b00: begin
                size_mask  = BE_W'(1);
                wdata_next = {BE_W{write_data[7:0]}};
            end
            2'b01: begin
                misaligned = alu_result[0];
                size_mask  = BE_W'(3);
                wdata_next = {(BE_W/2){write_data[15:0]}};
            end
            2'b10: begin
                misaligned = |alu_result[1:0];
                size_mask  = BE_W'(15);
                wdata_next = {(BE_W/4){write_data[31:0]}};
            end
            default: misaligned = (DATA_W == 32) || (|alu_result[2:0]);
        endcase
    end

    // Shift the addressed lane down, then keep the access width and fill above it.
    always_comb begin
        lane     = dmem_rdata >> {cap_off, 3'b000};
        keep     = '1;
        sign_bit = 1'b0;
        case (cap_size)
            2'b00: begin
                keep     = DATA_W'(8'hFF);
                sign_bit = lane[7];
            end
            2'b01: begin
                keep     = DATA_W'(16'hFFFF);
                sign_bit = lane[15];
            end
            2'b10: begin
                keep     = DATA_W'(32'hFFFF_FFFF);
                sign_bit = lane[31];
            end
            default: ;
        endcase
        load_fmt = (lane & keep) | ({DATA_W{sign_bit & ~cap_uns}} & ~keep);
    end

    always_comb begin
        next_state = state;
        start_req  = 1'b0;
        retire     = 1'b0;
        park       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem && !misaligned) begin
                        start_req  = 1'b1;
                        next_state = REQ;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (cap_load) begin
                        next_state = WAIT;
                    end else if (stall) begin
                        park       = 1'b1;
                        next_state = DONE;
                    end else begin
                        retire     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    if (stall) begin
                        park       = 1'b1;
                        next_state = DONE;
                    end else begin
                        retire     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            DONE: begin
                if (!stall) begin
                    retire     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write-back values: straight from the inputs in IDLE, from the capture registers otherwise.
    always_comb begin
        ret_result = cap_alu;
        ret_reg    = cap_reg;
        ret_rw     = cap_rw;
        ret_inst   = cap_inst;
        ret_err    = 1'b0;
        case (state)
            IDLE: begin
                ret_result = alu_result;
                ret_reg    = write_reg_in;
                ret_rw     = reg_write_in && !(is_mem && misaligned);
                ret_inst   = inst_in;
                ret_err    = is_mem && misaligned;
            end
            WAIT:    ret_result = load_fmt;
            DONE:    ret_result = res_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            cap_alu       <= '0;
            cap_reg       <= '0;
            cap_rw        <= 1'b0;
            cap_inst      <= '0;
            cap_load      <= 1'b0;
            cap_size      <= '0;
            cap_uns       <= 1'b0;
            cap_off       <= '0;
            res_q         <= '0;
            out_valid     <= 1'b0;
            final_result  <= '0;
            write_reg_out <= '0;
            reg_write_out <= 1'b0;
            inst_out      <= '0;
            addr_err      <= 1'b0;
        end else begin
            if (start_req) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write_in;
                dmem_addr  <= addr_next;
                dmem_be    <= be_next;
                dmem_wdata <= wdata_next;
                cap_alu    <= alu_result;
                cap_reg    <= write_reg_in;
                cap_rw     <= reg_write_in;
                cap_inst   <= inst_in;
                cap_load   <= mem_read_in;
                cap_size   <= mem_size;
                cap_uns    <= mem_unsigned;
                cap_off    <= in_off;
            end else if (state == REQ && dmem_gnt) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end

            if (park) begin
                res_q <= ret_result;
            end

            // Outputs only move on an unstalled edge, or when something retires.
            if (retire) begin
                out_valid     <= 1'b1;
                final_result  <= ret_result;
                write_reg_out <= ret_reg;
                reg_write_out <= ret_rw;
                inst_out      <= ret_inst;
                addr_err      <= ret_err;
            end else if (!stall) begin
                out_valid     <= 1'b0;
                reg_write_out <= 1'b0;
                addr_err      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu (DATA_W=32): vector table through a retirement scoreboard,
// plus hand sequences for stall hold, stalled completions and reset during an outstanding load.
module tb_mem_stage_lsu;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_AW = 5;
    localparam int BE_W   = 4;
    localparam int NVEC   = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_AW-1:0] write_reg_in;
    logic              reg_write_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [31:0]       inst_in;
    logic              stall;
    logic              busy;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [BE_W-1:0]   dmem_be;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] final_result;
    logic [REG_AW-1:0] write_reg_out;
    logic              reg_write_out;
    logic [31:0]       inst_out;
    logic              addr_err;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .write_data(write_data), .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .inst_in(inst_in), .stall(stall), .busy(busy),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .final_result(final_result),
        .write_reg_out(write_reg_out), .reg_write_out(reg_write_out), .inst_out(inst_out),
        .addr_err(addr_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic        rw;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        rv_in_gnt;
        logic [31:0] exp_res;
        logic        exp_err;
        logic        exp_rw;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rg;
        logic        rw;
        logic        err;
        logic [31:0] inst;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rg, input logic rw,
                            input logic err, input logic [31:0] inst);
        exp_t e;
        e.res  = res;
        e.rg   = rg;
        e.rw   = rw;
        e.err  = err;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic drive_op(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                            input logic wr, input logic [1:0] size, input logic uns,
                            input logic rw, input logic [4:0] rg, input logic [31:0] inst);
        in_valid     = 1'b1;
        alu_result   = addr;
        write_data   = wdata;
        mem_read_in  = rd;
        mem_write_in = wr;
        mem_size     = size;
        mem_unsigned = uns;
        reg_write_in = rw;
        write_reg_in = rg;
        inst_in      = inst;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d retirements still pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard: a retirement is an out_valid seen after an edge that was not stalled.
    initial begin
        exp_t e;
        logic st;
        logic rs;
        forever begin
            @(posedge clk);
            st = stall;
            rs = rst;
            #1;
            if (!rs && !st && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got out_valid=1 result=0x%0h, want no retirement", final_result);
                end else begin
                    e = exp_q.pop_front();
                    check("final_result", 64'(final_result), 64'(e.res));
                    check("write_reg_out", 64'(write_reg_out), 64'(e.rg));
                    check("reg_write_out", 64'(reg_write_out), 64'(e.rw));
                    check("addr_err", 64'(addr_err), 64'(e.err));
                    check("inst_out", 64'(inst_out), 64'(e.inst));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        logic [4:0]  rg;
        logic [31:0] inst;
        rg   = 5'(idx + 1);
        inst = 32'hC0DE_0000 | 32'(idx);
        @(negedge clk);
        drive_op(v.addr, v.wdata, v.rd, v.wr, v.size, v.uns, v.rw, rg, inst);
        push_exp(v.exp_res, rg, v.exp_rw, v.exp_err, inst);
        @(negedge clk);
        idle_inputs();
        if ((v.rd || v.wr) && !v.exp_err) begin
            check($sformatf("v%0d_req", idx), 64'(dmem_req), 64'(1));
            check($sformatf("v%0d_we", idx), 64'(dmem_we), 64'(v.wr));
            check($sformatf("v%0d_addr", idx), 64'(dmem_addr), 64'(v.exp_addr));
            check($sformatf("v%0d_be", idx), 64'(dmem_be), 64'(v.exp_be));
            if (v.wr) check($sformatf("v%0d_wdata", idx), 64'(dmem_wdata), 64'(v.exp_wdata));
            repeat (v.gnt_dly) @(negedge clk);
            check($sformatf("v%0d_req_held", idx), 64'(dmem_req), 64'(1));
            dmem_gnt = 1'b1;
            if (v.rv_in_gnt) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = 32'hDEAD_DEAD;
            end
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = '0;
            check($sformatf("v%0d_req_drop", idx), 64'(dmem_req), 64'(0));
            if (v.rd) begin
                repeat (v.rv_dly - 1) @(negedge clk);
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                @(negedge clk);
                dmem_rvalid = 1'b0;
                dmem_rdata  = '0;
            end
        end else begin
            check($sformatf("v%0d_no_req", idx), 64'(dmem_req), 64'(0));
            check($sformatf("v%0d_busy", idx), 64'(busy), 64'(0));
        end
        drain($sformatf("v%0d", idx));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        alu_result = '0; write_data = '0; write_reg_in = '0; reg_write_in = 1'b0;
        mem_size = '0; mem_unsigned = 1'b0; inst_in = '0; stall = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req", 64'(dmem_req), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(final_result), 64'(0));
        check("rst_be", 64'(dmem_be), 64'(0));
        rst = 1'b0;

        // addr, wdata, rd, wr, size, uns, rw, rdata, gnt_dly, rv_dly, rv_in_gnt, exp_res, exp_err, exp_rw, exp_be, exp_addr, exp_wdata
        vecs[0]  = '{32'h1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 0, 0, 1'b0, 32'h1234, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[1]  = '{32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h80FF_FF00, 2, 3, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1, 4'h8, 32'h100, 32'h0};
        vecs[2]  = '{32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h80FF_FF00, 2, 3, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 4'h8, 32'h100, 32'h0};
        vecs[3]  = '{32'h202, 32'hBEEF, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 1, 0, 1'b0, 32'h202, 1'b0, 1'b0, 4'hC, 32'h200, 32'hBEEF_BEEF};
        vecs[4]  = '{32'h102, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 0, 0, 1'b0, 32'h102, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
        vecs[5]  = '{32'h106, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h8001_1234, 0, 1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1, 4'hC, 32'h104, 32'h0};
        vecs[6]  = '{32'h104, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h1234_ABCD, 1, 2, 1'b0, 32'h0000_ABCD, 1'b0, 1'b1, 4'h3, 32'h104, 32'h0};
        vecs[7]  = '{32'h208, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 32'h208, 32'h0};
        vecs[8]  = '{32'h301, 32'h1234_56A5, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h301, 1'b0, 1'b0, 4'h2, 32'h300, 32'hA5A5_A5A5};
        vecs[9]  = '{32'h30C, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0, 3, 0, 1'b0, 32'h30C, 1'b0, 1'b1, 4'hF, 32'h30C, 32'hCAFE_F00D};
        vecs[10] = '{32'h400, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 0, 0, 1'b0, 32'h400, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
        vecs[11] = '{32'h203, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0, 0, 0, 1'b0, 32'h203, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
        vecs[12] = '{32'h2, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0080_0000, 1, 2, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1, 4'h4, 32'h0, 32'h0};
        vecs[13] = '{32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_007F, 0, 1, 1'b0, 32'h0000_007F, 1'b0, 1'b1, 4'h1, 32'h0, 32'h0};

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Bubble after a retirement clears out_valid and reg_write_out.
        @(negedge clk);
        check("bubble_out_valid", 64'(out_valid), 64'(0));
        check("bubble_reg_write", 64'(reg_write_out), 64'(0));

        // out_valid held through a stall counts once.
        @(negedge clk);
        drive_op(32'h5555, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd9, 32'hAAAA_0001);
        push_exp(32'h5555, 5'd9, 1'b1, 1'b0, 32'hAAAA_0001);
        @(negedge clk);
        idle_inputs();
        stall = 1'b1;
        check("alu_busy", 64'(busy), 64'(0));
        repeat (2) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_result", 64'(final_result), 64'(32'h5555));
        end
        stall = 1'b0;
        @(negedge clk);
        check("post_hold_out_valid", 64'(out_valid), 64'(0));
        drain("hold");

        // Load completing under a 3-cycle stall parks in DONE.
        @(negedge clk);
        drive_op(32'h40, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd10, 32'hAAAA_0002);
        push_exp(32'h1122_3344, 5'd10, 1'b1, 1'b0, 32'hAAAA_0002);
        @(negedge clk);
        idle_inputs();
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt    = 1'b0;
        stall       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1122_3344;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            dmem_rdata  = '0;
            check($sformatf("stall%0d_busy", k), 64'(busy), 64'(1));
            check($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'(0));
            check($sformatf("stall%0d_result", k), 64'(final_result), 64'(32'h5555));
            check($sformatf("stall%0d_reg", k), 64'(write_reg_out), 64'(9));
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_out_valid", 64'(out_valid), 64'(1));
        check("unstall_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("unstall_one_cycle", 64'(out_valid), 64'(0));
        drain("stall_load");

        // Store granted under stall retires only once stall drops.
        @(negedge clk);
        drive_op(32'h50, 32'h0BAD_F00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd11, 32'hAAAA_0003);
        push_exp(32'h50, 5'd11, 1'b0, 1'b0, 32'hAAAA_0003);
        @(negedge clk);
        idle_inputs();
        check("st_wdata", 64'(dmem_wdata), 64'(32'h0BAD_F00D));
        dmem_gnt = 1'b1;
        stall    = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("st_done_busy", 64'(busy), 64'(1));
        check("st_done_req", 64'(dmem_req), 64'(0));
        stall = 1'b0;
        @(negedge clk);
        check("st_retire_busy", 64'(busy), 64'(0));
        drain("stall_store");

        // Reset while waiting for read data; a late rvalid must be ignored.
        @(negedge clk);
        drive_op(32'h61, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd12, 32'hAAAA_0004);
        @(negedge clk);
        idle_inputs();
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("wait_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_req", 64'(dmem_req), 64'(0));
        check("arst_addr", 64'(dmem_addr), 64'(0));
        check("arst_be", 64'(dmem_be), 64'(0));
        check("arst_result", 64'(final_result), 64'(0));
        check("arst_reg", 64'(write_reg_out), 64'(0));
        check("arst_inst", 64'(inst_out), 64'(0));
        check("arst_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_FF00;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        check("stale_out_valid", 64'(out_valid), 64'(0));
        check("stale_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check("stale_out_valid_later", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised memory-access pipeline stage, placed between the execute and write-back stages. It supports byte, halfword, word and (when DATA_W=64) doubleword loads and stores. Loads are sign- or zero-extended, and misaligned accesses are detected. Data memory is reached through a req/gnt/rvalid handshake with variable latency. The stage back-pressures upstream with busy, honours a downstream stall, and registers the result for write-back.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
ADDR_W, 32, memory address width.
REG_AW, 5, register-file index width.
BE_W, DATA_W/8, byte-enable width (derived; not overridden).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  execute stage presents an instruction
alu_result  in  DATA_W  ALU result; also the memory address (low ADDR_W bits)
write_data  in  DATA_W  store data (right-aligned)
write_reg_in  in  REG_AW  destination register
reg_write_in  in  1  register write enable
mem_read_in  in  1  load
mem_write_in  in  1  store (mem_read_in and mem_write_in never both 1)
mem_size  in  2  00 byte, 01 half, 10 word, 11 dword
mem_unsigned  in  1  zero-extend loads
inst_in  in  32  instruction word, passed through
stall  in  1  downstream hold
busy  out  1  stage cannot accept; upstream must hold
dmem_req  out  1  memory request
dmem_we  out  1  write request
dmem_addr  out  ADDR_W  address, aligned to BE_W bytes
dmem_be  out  BE_W  byte enables
dmem_wdata  out  DATA_W  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  DATA_W  read data
out_valid  out  1  write-back outputs valid
final_result  out  DATA_W  formatted load data or alu_result
write_reg_out  out  REG_AW  destination register
reg_write_out  out  1  final register write enable
inst_out  out  32  instruction word
addr_err  out  1  misaligned or illegal-size access retired

Behaviour:
- Reset (rst=1, async): FSM to IDLE. busy, dmem_req, dmem_we, out_valid, reg_write_out, addr_err = 0. All data outputs, dmem_addr, dmem_be, write_reg_out and inst_out = 0. An in-flight request is abandoned; any later gnt/rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE. busy = (state != IDLE).
- Accept condition: in_valid & ~busy & ~stall in IDLE.
- Non-memory op: outputs registered at the next edge; latency 1. final_result = alu_result.
- Misalignment: the address is not a multiple of the access size, or mem_size=11 with DATA_W=32.
- Misaligned or illegal memory op: no request is issued. Retires at the next edge with addr_err=1, reg_write_out=0, final_result=alu_result.
- Legal memory op: captured, then IDLE->REQ. dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable until dmem_gnt.
- Store: REQ->IDLE on gnt and retires at that edge, with reg_write_out = reg_write_in.
- Load: REQ->WAIT on gnt; retires at the edge where dmem_rvalid=1.
- dmem_rvalid never arrives in the gnt cycle; if it does, it is ignored.
- Byte lane offset = addr[log2(BE_W)-1:0]. dmem_be has size-many ones shifted by the offset.
- Stores replicate write_data's low byte, half or word across all lanes.
- Loads extract the lane and sign- or zero-extend to DATA_W.
- Stall=1: all write-back outputs hold, including out_valid.
  - A completion during stall goes to DONE with the result buffered.
  - DONE->IDLE on the first cycle with stall=0, when the outputs update.
- out_valid=1 for exactly one unstalled cycle per retired instruction; otherwise 0.
- Bubble: in IDLE with in_valid=0 and no stall, out_valid=0 at the next edge and reg_write_out=0.

Test Plan:
1. Reset held mid-WAIT -> all outputs 0 and FSM IDLE. A stale rvalid one cycle after release is ignored: out_valid stays 0.
2. Non-memory ALU op, alu_result=0x1234, reg 7 -> next edge: out_valid=1, final_result=0x1234, write_reg_out=7, busy stays 0.
3. Byte load, signed, addr 0x103, rdata=0x80FF_FF00, gnt after 2 cycles, rvalid after 3 -> dmem_be=1000, dmem_addr=0x100, final_result=0xFFFF_FF80. With mem_unsigned=1: final_result=0x0000_0080.
4. Halfword store 0xBEEF to 0x202 -> dmem_we=1, dmem_be=1100, dmem_wdata=0xBEEF_BEEF, retires on the gnt edge.
5. Word load at 0x102 -> no dmem_req, addr_err=1, reg_write_out=0.
6. Load completes while stall=1 for 3 cycles -> outputs hold the prior values, busy=1. Result appears on the first unstalled edge with out_valid=1 for one cycle.
